// File: rtl/layernorm_mean_unit.sv
`default_nettype none
// ============================================================================
// Module   : layernorm_mean_unit
// Brief    : Mean of one D_MODEL-element signed token vector, NUM_PE elements
//            per cycle, with a latched copy of the vector for variance_unit.
// Revision : 1.0 - initial release
// ============================================================================
module layernorm_mean_unit #(
    parameter int D_MODEL    = 128,
    parameter int DATA_WIDTH = 24,
    parameter int NUM_PE     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [D_MODEL*DATA_WIDTH-1:0] data_in_flat,
    input  logic                          start_mean,
    output logic [D_MODEL*DATA_WIDTH-1:0] data_out_flat,
    output logic [DATA_WIDTH-1:0]         mean_out,
    output logic                          mean_valid,
    output logic                          busy
);

    localparam int LOG2_D     = $clog2(D_MODEL);
    localparam int ACC_WIDTH  = DATA_WIDTH + LOG2_D;
    localparam int NUM_CHUNKS = D_MODEL / NUM_PE;
    localparam int CNT_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CHUNK_BITS = NUM_PE * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CHUNK = CNT_WIDTH'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [D_MODEL*DATA_WIDTH-1:0] vec_q;
    logic [ACC_WIDTH-1:0]          acc_q;
    logic [CNT_WIDTH-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]         mean_q;
    logic                          busy_q, busy_d;
    logic                          valid_q, valid_d;

    logic [CHUNK_BITS-1:0]         w_chunks [NUM_CHUNKS];
    logic [CHUNK_BITS-1:0]         w_chunk;
    logic [ACC_WIDTH-1:0]          w_chunk_sum;

    generate
        for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
            assign w_chunks[c] = vec_q[c*CHUNK_BITS +: CHUNK_BITS];
        end
    endgenerate

    // Sign-extend each element to accumulator width before summing.
    always_comb begin
        w_chunk     = w_chunks[cnt_q];
        w_chunk_sum = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_chunk_sum = w_chunk_sum +
                {{LOG2_D{w_chunk[i*DATA_WIDTH + DATA_WIDTH - 1]}},
                 w_chunk[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_mean) begin
                    state_d = S_ACCUM;
                    busy_d  = 1'b1;
                end
            end
            S_ACCUM: begin
                if (cnt_q == LAST_CHUNK) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            case (state_q)
                S_IDLE: begin
                    if (start_mean) begin
                        vec_q <= data_in_flat;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_q + w_chunk_sum;
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
                // Dropping the low LOG2_D bits is an arithmetic shift (floor).
                S_DONE: mean_q <= acc_q[ACC_WIDTH-1:LOG2_D];
                default: ;
            endcase
        end
    end

    assign data_out_flat = vec_q;
    assign mean_out      = mean_q;
    assign mean_valid    = valid_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_layernorm_mean_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_layernorm_mean_unit
// Brief    : Directed scoreboard bench for layernorm_mean_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layernorm_mean_unit;

    localparam int D       = 128;
    localparam int W       = 24;
    localparam int LATENCY = 17;

    typedef struct {
        logic [W-1:0]   mean;
        logic [D*W-1:0] vec;
        int             cyc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [D*W-1:0] data_in_flat;
    logic           start_mean;
    logic [D*W-1:0] data_out_flat;
    logic [W-1:0]   mean_out;
    logic           mean_valid;
    logic           busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    layernorm_mean_unit #(
        .D_MODEL    (D),
        .DATA_WIDTH (W),
        .NUM_PE     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_flat  (data_in_flat),
        .start_mean    (start_mean),
        .data_out_flat (data_out_flat),
        .mean_out      (mean_out),
        .mean_valid    (mean_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [D*W-1:0] fill(input logic [W-1:0] v);
        logic [D*W-1:0] r;
        for (int i = 0; i < D; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [D*W-1:0] ramp();
        logic [D*W-1:0] r;
        for (int i = 0; i < D; i++) r[i*W +: W] = W'(i);
        return r;
    endfunction

    function automatic logic [D*W-1:0] half_split();
        logic [D*W-1:0] r;
        for (int i = 0; i < D; i++) r[i*W +: W] = (i < D/2) ? W'(1000) : -W'(1001);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Call right after a negedge; returns one negedge later with start low.
    task automatic issue(input logic [D*W-1:0] v, input logic [W-1:0] m, input bit expect_done);
        exp_t e;
        data_in_flat = v;
        start_mean   = 1'b1;
        if (expect_done) begin
            e.mean = m;
            e.vec  = v;
            e.cyc  = cyc + 1 + LATENCY;
            sb.push_back(e);
        end
        @(negedge clk);
        start_mean = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every mean_valid pulse.
    always @(negedge clk) begin
        if (mean_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: mean_valid high at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                int   bad;
                e = sb.pop_front();
                check("mean_out", mean_out, e.mean);
                check("busy_during_valid", W'(busy), W'(0));
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL latency: valid at cycle %0d expected %0d", cyc, e.cyc);
                end
                bad = -1;
                for (int i = D - 1; i >= 0; i--)
                    if (data_out_flat[i*W +: W] !== e.vec[i*W +: W]) bad = i;
                checks++;
                if (bad >= 0) begin
                    failures++;
                    $display("FAIL data_out_flat: element %0d got %h expected %h",
                             bad, data_out_flat[bad*W +: W], e.vec[bad*W +: W]);
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        start_mean   = 1'b0;
        data_in_flat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_mean_out", mean_out, '0);
        check("reset_data_out", W'(data_out_flat != '0), W'(0));
        check("reset_mean_valid", W'(mean_valid), W'(0));
        check("reset_busy", W'(busy), W'(0));
        @(negedge clk);

        issue(fill(W'(100)), W'(100), 1'b1);
        check("busy_after_start", W'(busy), W'(1));
        repeat (18) @(negedge clk);

        issue(ramp(), W'(63), 1'b1);
        repeat (18) @(negedge clk);
        issue(fill(-W'(5)), 24'hFFFFFB, 1'b1);
        repeat (18) @(negedge clk);
        issue(half_split(), 24'hFFFFFF, 1'b1);
        repeat (18) @(negedge clk);
        issue(fill(24'h7FFFFF), 24'h7FFFFF, 1'b1);
        repeat (18) @(negedge clk);
        issue(fill(24'h800000), 24'h800000, 1'b1);
        repeat (18) @(negedge clk);

        // Input change plus ignored start mid-run, then back-to-back restart.
        issue(fill(W'(100)), W'(100), 1'b1);
        repeat (4) @(negedge clk);
        data_in_flat = fill(W'(7));
        start_mean   = 1'b1;
        @(negedge clk);
        start_mean   = 1'b0;
        repeat (12) @(negedge clk);
        issue(fill(W'(7)), W'(7), 1'b1);
        repeat (18) @(negedge clk);

        // Reset at processing cycle 8, with a start presented alongside it.
        issue(ramp(), '0, 1'b0);
        repeat (7) @(negedge clk);
        rst        = 1'b1;
        start_mean = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        start_mean = 1'b0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_mean_out", mean_out, '0);
        check("abort_data_out", W'(data_out_flat != '0), W'(0));
        repeat (20) @(negedge clk);
        check("abort_stays_idle", W'(busy), W'(0));

        issue(fill(-W'(5)), 24'hFFFFFB, 1'b1);
        repeat (20) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_valid: %0d expected results never arrived", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
